// File: rtl/instruction_fetch_unit_if.sv
// Bus between the instruction fetch unit, the combinational instruction
// memory and the decode stage.
// The master side is the fetch unit and the slave side is the environment,
// which is the memory plus decode.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
);

  // Memory request and response
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_en;
  logic [INSTR_WIDTH-1:0] imem_instr;

  // Control-flow redirect coming back from the execute side
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;

  // Decode handshake
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;

  // Status
  logic                   halted;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// Holds the program counter and drives it straight onto the combinational
// instruction memory. Every instruction returned is captured, together with
// its address, into a small circular buffer. Decode drains that buffer
// through a valid/ready handshake.
// A branch redirect flushes the buffer and restarts fetch at the new PC.
// Fetching a HALT opcode parks the FSM until the next redirect.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input logic                    clk,
  input logic                    reset,
  instruction_fetch_unit_if.master bus
);

  // DEPTH must be a power of two, so the pointers wrap naturally.
  // The count needs one extra bit so that it can hold the full value.
  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]    C_DEPTH = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [PTR_W-1:0]       r_wrPtr;
  logic [PTR_W-1:0]       r_rdPtr;
  logic [PTR_W:0]         r_count;
  logic [INSTR_WIDTH-1:0] r_instrBuf [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_pcBuf    [DEPTH];

  logic w_outValid;
  logic w_pop;
  logic w_push;
  logic w_isHalt;

  // Handshake decode.
  // A pop frees a slot in the same cycle, so a full buffer can still accept
  // a push while decode is draining it.
  assign w_outValid = (r_count != '0);
  assign w_pop      = w_outValid & bus.out_ready;
  assign w_push     = (r_state == RUN) & ~bus.redirect_valid &
                      ((r_count < C_DEPTH) | w_pop);
  assign w_isHalt   = (bus.imem_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  assign bus.imem_addr = r_pc;
  assign bus.imem_en   = w_push;
  assign bus.out_valid = w_outValid;
  assign bus.out_instr = r_instrBuf[r_rdPtr];
  assign bus.out_pc    = r_pcBuf[r_rdPtr];
  assign bus.halted    = (r_state == HALTED);

  // Buffer storage: capture the fetched word and its address on every push.
  // It has no reset because contents are only observed while the count
  // is nonzero.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_instrBuf[r_wrPtr] <= bus.imem_instr;
      r_pcBuf[r_wrPtr]    <= r_pc;
    end
  end

  // Fetch FSM plus PC, pointers and occupancy.
  // Priority order is reset, then redirect, then normal push/pop.
  // A redirect drops everything in flight, including a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_state <= RUN;
      r_pc    <= bus.redirect_pc;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc    <= r_pc + ADDR_WIDTH'(1);
        r_wrPtr <= r_wrPtr + PTR_W'(1);
        if (w_isHalt) begin
          r_state <= HALTED;
        end
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
